// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - shared FSM encoding, local register offsets and abort data for the J1 I/O bridge
package j1_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  REG_STATUS   = 8'h00;
    localparam logic [7:0]  REG_TO_ADDR  = 8'h01;
    localparam logic [7:0]  REG_CYC_LO   = 8'h02;
    localparam logic [7:0]  REG_CYC_HI   = 8'h03;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/j1_io_regs.sv
// rtl/j1_io_regs.sv - local register page: timeout status, timeout address, optional cycle counter
// Optional feature: J1_IO_BRIDGE_CYCCNT_EN adds a 32-bit cycle counter at offsets 02/03.
module j1_io_regs
    import j1_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [7:0]  i_offset,
    input  logic        i_wdata0,
    input  logic        i_to_set,
    input  logic [15:0] i_to_addr,
    output logic [15:0] o_rdata
);

    logic        r_to_flag;
    logic [15:0] r_to_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_flag <= 1'b0;
            r_to_addr <= 16'h0000;
        end else if (i_to_set) begin
            r_to_flag <= 1'b1;
            r_to_addr <= i_to_addr;
        end else if (i_wr_en && i_offset == REG_STATUS && i_wdata0) begin
            r_to_flag <= 1'b0;
        end
    end

`ifdef J1_IO_BRIDGE_CYCCNT_EN
    logic [31:0] r_cyc;
    logic [15:0] r_cyc_hi;

    // Reading the low half freezes the matching high half for the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc    <= 32'h0;
            r_cyc_hi <= 16'h0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (i_rd_en && i_offset == REG_CYC_LO)
                r_cyc_hi <= r_cyc[31:16];
        end
    end
`endif

    always_comb begin
        o_rdata = 16'h0000;
        case (i_offset)
            REG_STATUS:  o_rdata = {15'h0000, r_to_flag};
            REG_TO_ADDR: o_rdata = r_to_addr;
`ifdef J1_IO_BRIDGE_CYCCNT_EN
            REG_CYC_LO:  o_rdata = r_cyc[15:0];
            REG_CYC_HI:  o_rdata = r_cyc_hi;
`endif
            default:     o_rdata = 16'h0000;
        endcase
    end

endmodule

// File: rtl/j1_io_bridge.sv
// rtl/j1_io_bridge.sv - J1 I/O responder: zero-wait local page, paused req/ack forwarding with timeout
// Optional feature: J1_IO_BRIDGE_CYCCNT_EN (cycle counter in the local page).
module j1_io_bridge
    import j1_io_pkg::*;
#(
    parameter logic [7:0]         LOCAL_PAGE = 8'hFF,
    parameter int                 TO_BITS    = 8,
    parameter logic [TO_BITS-1:0] TIMEOUT    = 8'd200
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        pause,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic [15:0] ext_rdata,
    input  logic        ext_ack
);

    localparam logic [TO_BITS-1:0] TO_LAST = TIMEOUT - 1'b1;

    state_t             r_state;
    logic [TO_BITS-1:0] r_count;
    logic [15:0]        r_rdata_q;

    logic        w_local;
    logic        w_acc;
    logic        w_to_fire;
    logic [15:0] w_reg_rdata;

    assign w_local   = (io_addr[15:8] == LOCAL_PAGE);
    assign w_acc     = io_rd | io_wr;
    assign w_to_fire = (r_state == ST_WAIT) && !ext_ack && (r_count == TO_LAST);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_rdata_q <= 16'h0000;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= 16'h0000;
            ext_wdata <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc && !w_local) begin
                        r_state   <= ST_WAIT;
                        r_count   <= '0;
                        ext_req   <= 1'b1;
                        ext_we    <= io_wr;
                        ext_addr  <= io_addr;
                        ext_wdata <= io_dout;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count + 1'b1;
                    // An ack on the final timeout cycle still completes normally.
                    if (ext_ack) begin
                        r_rdata_q <= ext_rdata;
                        ext_req   <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_count == TO_LAST) begin
                        r_rdata_q <= TIMEOUT_DATA;
                        ext_req   <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    j1_io_regs u_regs (
        .clk       (sys_clk_i),
        .rst_n     (sys_rst_n_i),
        .i_wr_en   ((r_state == ST_IDLE) && io_wr && w_local),
        .i_rd_en   ((r_state == ST_IDLE) && io_rd && !io_wr && w_local),
        .i_offset  (io_addr[7:0]),
        .i_wdata0  (io_dout[0]),
        .i_to_set  (w_to_fire),
        .i_to_addr (ext_addr),
        .o_rdata   (w_reg_rdata)
    );

    // Strobes repeat during reset, so pause is gated to keep the core free.
    assign pause = sys_rst_n_i &&
                   ((r_state == ST_WAIT) || ((r_state == ST_IDLE) && w_acc && !w_local));

    always_comb begin
        io_din = 16'h0000;
        if (sys_rst_n_i) begin
            if (r_state == ST_IDLE && w_acc && w_local)
                io_din = w_reg_rdata;
            else if (r_state == ST_DONE)
                io_din = r_rdata_q;
        end
    end

endmodule
